// File: rtl/cmt_pkg.sv
// cmt_pkg: CMT register map, sequencer FSM states and write-step indices
package cmt_pkg;
  localparam logic [7:0] CMT_A_STR     = 8'h00;
  localparam logic [7:0] CMT_A_CSR0    = 8'h04;
  localparam logic [7:0] CMT_A_CNT0    = 8'h08;
  localparam logic [7:0] CMT_A_COR0    = 8'h0C;
  localparam logic [7:0] CMT_CH_STRIDE = 8'h10;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SETUP, S_ACCESS, S_DONE} state_t;
  typedef enum logic [2:0] {W_STR_OFF, W_CSR, W_COR, W_CNT, W_STR_ON} step_t;
endpackage

// File: rtl/cmt_rr_arb.sv
// cmt_rr_arb: round-robin arbiter, first set request scanning upward from ptr with wrap
module cmt_rr_arb #(
  parameter int NREQ = 2,
  parameter int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    idx = '0;
    for (int o = NREQ - 1; o >= 0; o--)
      if (req[(int'(ptr) + o) % NREQ]) idx = IW'((int'(ptr) + o) % NREQ);
    any = |req;
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/cmt_cfg_seq.sv
// cmt_cfg_seq: arbitrates channel setup requests and expands each into CMT APB writes
module cmt_cfg_seq import cmt_pkg::*; #(
  parameter int NREQ = 2,
  parameter logic [7:0] A_STR     = CMT_A_STR,
  parameter logic [7:0] A_CSR0    = CMT_A_CSR0,
  parameter logic [7:0] A_CNT0    = CMT_A_CNT0,
  parameter logic [7:0] A_COR0    = CMT_A_COR0,
  parameter logic [7:0] CH_STRIDE = CMT_CH_STRIDE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      req_ch_i,
  input  logic [NREQ-1:0]      req_start_i,
  input  logic [2*NREQ-1:0]    req_cks_i,
  input  logic [16*NREQ-1:0]   req_const_i,
  output logic [NREQ-1:0]      ack_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [7:0]           paddr_o,
  output logic [31:0]          pwdata_o,
  input  logic                 pready_i,
  input  logic                 pslverr_i
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state, state_nx;
  step_t step;
  logic [IW-1:0] rr_ptr, a_idx;
  logic [NREQ-1:0] a_gnt, gnt_q;
  logic a_any, ch, start, err, last, str_wr;
  logic [1:0] cks, shadow, bit_ch;
  logic [15:0] cnst;
  logic [7:0] base, addr;
  logic [31:0] data;

  cmt_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req_i), .ptr(rr_ptr), .gnt(a_gnt), .idx(a_idx), .any(a_any)
  );

  always_comb begin
    bit_ch = ch ? 2'b10 : 2'b01;
    last = !start || step == W_STR_ON;
    str_wr = step == W_STR_OFF || step == W_STR_ON;
    base = step == W_CSR ? A_CSR0 : step == W_COR ? A_COR0 : A_CNT0;
    addr = str_wr ? A_STR : base + (ch ? CH_STRIDE : 8'h00);
    data = step == W_STR_OFF ? {30'b0, shadow & ~bit_ch}
         : step == W_STR_ON  ? {30'b0, shadow | bit_ch}
         : step == W_CSR     ? {30'b0, cks}
         : step == W_COR     ? {16'b0, cnst} : 32'b0;
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = a_any ? S_GRANT : S_IDLE;
      S_GRANT:  state_nx = a_any ? S_SETUP : S_IDLE;
      S_SETUP:  state_nx = S_ACCESS;
      S_ACCESS: state_nx = !pready_i ? S_ACCESS : (pslverr_i || last) ? S_DONE : S_SETUP;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign psel_o    = state == S_SETUP || state == S_ACCESS;
  assign penable_o = state == S_ACCESS;
  assign pwrite_o  = 1'b1;
  assign paddr_o   = psel_o ? addr : 8'h00;
  assign pwdata_o  = psel_o ? data : 32'h0;
  assign busy_o    = state != S_IDLE;
  assign ack_o     = state == S_DONE ? gnt_q : '0;
  assign err_o     = state == S_DONE && err;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_ptr <= '0;
      gnt_q  <= '0;
      ch     <= 1'b0;
      start  <= 1'b0;
      cks    <= 2'b00;
      cnst   <= 16'h0;
      step   <= W_STR_OFF;
      shadow <= 2'b00;
      err    <= 1'b0;
    end else if (state == S_GRANT && a_any) begin
      rr_ptr <= IW'((int'(a_idx) + 1) % NREQ);
      gnt_q  <= a_gnt;
      ch     <= req_ch_i[a_idx];
      start  <= req_start_i[a_idx];
      cks    <= req_cks_i[2*int'(a_idx) +: 2];
      cnst   <= req_const_i[16*int'(a_idx) +: 16];
      step   <= W_STR_OFF;
      err    <= 1'b0;
    end else if (state == S_ACCESS && pready_i) begin
      // an errored write leaves the shadow alone and ends the sequence
      err <= pslverr_i;
      if (!pslverr_i && str_wr) shadow <= data[1:0];
      if (!pslverr_i && !last) step <= step_t'(step + 3'd1);
    end
endmodule

// File: tb/tb_cmt_cfg_seq.sv
// tb_cmt_cfg_seq: scoreboard bench with a write-list reference model and a scripted APB slave
module tb_cmt_cfg_seq;
  localparam int NREQ = 2;
  logic clk = 0, rst = 0;
  logic [NREQ-1:0] req_i = 0, req_ch_i = 0, req_start_i = 0;
  logic [2*NREQ-1:0] req_cks_i = 0;
  logic [16*NREQ-1:0] req_const_i = 0;
  logic [NREQ-1:0] ack_o;
  logic err_o, busy_o, psel_o, penable_o, pwrite_o;
  logic [7:0] paddr_o;
  logic [31:0] pwdata_o;
  logic pready_i = 0, pslverr_i = 0;

  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  typedef struct {int k; logic e; int lat;} ack_t;
  typedef struct {int w; logic e;} sl_t;
  wr_t exp_q[$];
  ack_t ack_q[$];
  sl_t sl_q[$];
  int checks = 0, errors = 0, cyc = 0;
  logic [1:0] m_shadow = 0;
  int m_ptr = 0;
  int r_ch[NREQ], r_st[NREQ], r_cks[NREQ], r_cst[NREQ], r_err[NREQ], r_wat[NREQ], r_wn[NREQ];
  bit rnd_w = 0;

  cmt_cfg_seq #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_ch_i(req_ch_i), .req_start_i(req_start_i),
    .req_cks_i(req_cks_i), .req_const_i(req_const_i), .ack_o(ack_o), .err_o(err_o),
    .busy_o(busy_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  task automatic bad(input string n);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", n, cyc);
  endtask

  // each sequence is the register write list derived from the requester's setup
  task automatic plan(input int k);
    logic [1:0] sh, b;
    wr_t w;
    int n, lat;
    logic e;
    sh = m_shadow;
    b = 2'(1 << r_ch[k]);
    n = r_st[k] != 0 ? 5 : 1;
    lat = 2;
    e = 0;
    for (int i = 1; i <= n; i++) begin
      int wt;
      case (i)
        1: w = '{8'h00, {30'b0, sh & ~b}};
        2: w = '{8'(4 + 16 * r_ch[k]), 32'(r_cks[k])};
        3: w = '{8'(12 + 16 * r_ch[k]), 32'(r_cst[k])};
        4: w = '{8'(8 + 16 * r_ch[k]), 32'h0};
        default: w = '{8'h00, {30'b0, sh | b}};
      endcase
      wt = rnd_w ? int'($urandom_range(0, 2)) : (i == r_wat[k] ? r_wn[k] : 0);
      e = i == r_err[k];
      exp_q.push_back(w);
      sl_q.push_back(sl_t'{wt, e});
      lat += 2 + wt;
      if (e) break;
      if (i == 1 || i == 5) sh = w.d[1:0];
    end
    m_shadow = sh;
    ack_q.push_back(ack_t'{k, e, lat});
  endtask

  task automatic set_r(input int k, input int ch, input int st, input int cks, input int cst,
                       input int er, input int wat, input int wn);
    r_ch[k] = ch; r_st[k] = st; r_cks[k] = cks; r_cst[k] = cst;
    r_err[k] = er; r_wat[k] = wat; r_wn[k] = wn;
  endtask

  task automatic drive(input logic [NREQ-1:0] mask);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_ch_i[i] = r_ch[i][0];
      req_start_i[i] = r_st[i] != 0;
      req_cks_i[2*i +: 2] = 2'(r_cks[i]);
      req_const_i[16*i +: 16] = 16'(r_cst[i]);
    end
    req_i = mask;
  endtask

  task automatic wait_done();
    int t = 0;
    while (req_i != 0 && t < 400) begin
      @(negedge clk);
      t++;
      req_i = req_i & ~ack_o;
    end
    if (req_i != 0) begin
      bad("ack_timeout");
      req_i = 0;
    end
    repeat (2) @(negedge clk);
    chk("writes_drained", exp_q.size(), 0);
    chk("acks_drained", ack_q.size(), 0);
  endtask

  task automatic run(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    pend = mask;
    while (pend != 0) begin
      int k;
      k = m_ptr;
      while (!pend[k]) k = (k + 1) % NREQ;
      plan(k);
      m_ptr = (k + 1) % NREQ;
      pend[k] = 0;
    end
    drive(mask);
    wait_done();
  endtask

  initial begin : slave
    bit act;
    int cnt;
    sl_t s;
    act = 0; cnt = 0; s = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (psel_o && penable_o) begin
        if (!act) begin
          act = 1;
          s = sl_q.size() > 0 ? sl_q.pop_front() : sl_t'{0, 0};
          cnt = s.w;
        end else if (cnt > 0) cnt--;
        pready_i = cnt == 0;
        pslverr_i = cnt == 0 && s.e;
      end else begin
        act = 0;
        pready_i = 0;
        pslverr_i = 0;
      end
    end
  end

  initial begin : monitor
    logic pb, pp, pe;
    logic [7:0] sa;
    logic [31:0] sd;
    int st;
    wr_t w;
    ack_t a;
    pb = 0; pp = 0; pe = 0; sa = 0; sd = 0; st = 0;
    forever begin
      @(negedge clk);
      if (busy_o && !pb) st = cyc;
      if (!busy_o) chk("apb_idle", {psel_o, penable_o}, 2'b00);
      if (psel_o && !penable_o) begin
        sa = paddr_o;
        sd = pwdata_o;
      end
      if (psel_o && penable_o) begin
        if (!pe) chk("setup_before_access", {pp, pe}, 2'b10);
        chk("addr_stable", paddr_o, sa);
        chk("data_stable", pwdata_o, sd);
        if (pready_i) begin
          if (exp_q.size() == 0) bad("unexpected_write");
          else begin
            w = exp_q.pop_front();
            chk("paddr", paddr_o, w.a);
            chk("pwdata", pwdata_o, w.d);
            chk("pwrite", pwrite_o, 1);
          end
        end
      end
      if (ack_o != 0) begin
        if (ack_q.size() == 0) bad("unexpected_ack");
        else begin
          a = ack_q.pop_front();
          chk("ack", ack_o, 1 << a.k);
          chk("err", err_o, a.e);
          chk("latency", cyc - st + 1, a.lat);
        end
      end else if (err_o) bad("err_without_ack");
      pb = busy_o; pp = psel_o; pe = penable_o;
    end
  end

  initial begin
    int t;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_apb", {psel_o, penable_o}, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    rst = 0;
    @(negedge clk);
    set_r(0, 0, 1, 2, 16'h0100, 0, 0, 0);
    run(2'b01);
    set_r(1, 1, 1, 1, 16'h1234, 0, 0, 0);
    run(2'b10);
    set_r(0, 0, 0, 0, 0, 0, 0, 0);
    run(2'b01);
    set_r(0, 0, 1, 3, 16'haaaa, 0, 0, 0);
    set_r(1, 1, 1, 2, 16'h5555, 0, 0, 0);
    repeat (2) run(2'b11);
    set_r(0, 1, 1, 1, 16'h0f0f, 0, 3, 3);
    run(2'b01);
    set_r(0, 0, 1, 2, 16'h7777, 2, 0, 0);
    run(2'b01);
    set_r(1, 0, 1, 1, 16'h2222, 0, 0, 0);
    run(2'b10);
    // reset while the channel counter write is being held off by the slave
    set_r(0, 1, 1, 1, 16'hbeef, 0, 4, 5);
    plan(0);
    drive(2'b01);
    t = 0;
    while (!(psel_o && penable_o && paddr_o == 8'h18) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) bad("write4_timeout");
    rst = 1;
    #1;
    chk("rst_mid_apb", {psel_o, penable_o}, 0);
    chk("rst_mid_busy", busy_o, 0);
    exp_q.delete(); ack_q.delete(); sl_q.delete();
    m_shadow = 0;
    m_ptr = 0;
    set_r(0, 1, 1, 1, 16'hbeef, 0, 0, 0);
    plan(0);
    m_ptr = 1;
    @(negedge clk);
    rst = 0;
    wait_done();
    rnd_w = 1;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < NREQ; i++)
        set_r(i, $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
              $urandom_range(0, 65535), $urandom_range(0, 9), 0, 0);
      run(NREQ'($urandom_range(1, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
